// File: rtl/updi_rx_phy_if.sv
// Bundle of the UPDI receive PHY signals.
//   master : line/host side. Drives rx_en, baud_div, rx and out_fifo_full, and observes the PHY outputs.
//   slave  : the PHY. Observes the line and the FIFO, and drives busy, the FIFO write and the
//            status pulses.
interface updi_rx_phy_if #(
  parameter int unsigned BaudBits = 16
) ();
  logic                rx_en;
  logic [BaudBits-1:0] baud_div;
  logic                rx;
  logic                busy;
  logic [7:0]          out_fifo_data;
  logic                out_fifo_full;
  logic                out_fifo_wr_en;
  logic                parity_error;
  logic                frame_error;
  logic                overflow;
  logic                break_detected;

  modport master (
    output rx_en, baud_div, rx, out_fifo_full,
    input  busy, out_fifo_data, out_fifo_wr_en, parity_error, frame_error, overflow,
           break_detected
  );

  modport slave (
    input  rx_en, baud_div, rx, out_fifo_full,
    output busy, out_fifo_data, out_fifo_wr_en, parity_error, frame_error, overflow,
           break_detected
  );
endinterface

// File: rtl/updi_rx_phy.sv
// Receive-side UPDI physical layer. It oversamples the line and deframes characters made of
// 1 start bit, 8 data bits (LSB first), even parity and 2 stop bits. Good bytes are written to
// the receive FIFO. The block pulses parity_error, frame_error, overflow and break_detected.
//   clk_i    : system clock, posedge
//   rst_ni   : asynchronous active-low reset
//   bus_io   : updi_rx_phy_if.slave. It carries rx_en, baud_div and rx (an asynchronous line),
//              the FIFO write port and the one-cycle status pulses.
module updi_rx_phy #(
  parameter int unsigned BaudBits = 16
) (
  input logic          clk_i,
  input logic          rst_ni,
  updi_rx_phy_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2, StWaitHigh
  } state_e;

  state_e state_q, state_d;

  logic                rx_meta_q, rx_s_q;
  logic [BaudBits-1:0] div_q, div_d;
  logic [BaudBits-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                acc_q, acc_d;     // running XOR of data bits
  logic                perr_q, perr_d;   // parity mismatch held until commit
  logic                pbit_q, pbit_d;   // received parity bit, needed for BREAK
  logic [7:0]          data_q, data_d;
  logic                wr_q, wr_d;
  logic                par_err_q, par_err_d;
  logic                frm_err_q, frm_err_d;
  logic                ovf_q, ovf_d;
  logic                brk_q, brk_d;
  logic                expire;

  // The counter is loaded with the interval and counts down. A sample is taken on the edge
  // where it reads 1. This places the samples exactly at t0+h and then at every div after that.
  assign expire = (cnt_q[BaudBits-1:1] == '0);

  // Two-flop synchroniser. It idles high so that reset does not look like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus_io.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (!bus_io.rx_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (!rx_s_q) state_d = StStart;
        StStart:    if (expire) state_d = rx_s_q ? StIdle : StData;
        StData:     if (expire && bit_q == 3'd7) state_d = StParity;
        StParity:   if (expire) state_d = StStop1;
        StStop1:    if (expire) state_d = rx_s_q ? StStop2 : StWaitHigh;
        StStop2:    if (expire) state_d = rx_s_q ? StIdle : StWaitHigh;
        StWaitHigh: if (rx_s_q) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Datapath next state: bit timing, shift register and parity
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    pbit_d  = pbit_q;
    if (!bus_io.rx_en) begin
      cnt_d = '0;
      bit_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            div_d = bus_io.baud_div;
            cnt_d = bus_io.baud_div >> 1;
            bit_d = '0;
            acc_d = 1'b0;
          end
        end
        StStart, StData, StParity, StStop1, StStop2: begin
          cnt_d = expire ? div_q : cnt_q - BaudBits'(1);
          if (expire && state_q == StData) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            acc_d   = acc_q ^ rx_s_q;
            bit_d   = bit_q + 3'd1;
          end
          if (expire && state_q == StParity) begin
            perr_d = acc_q ^ rx_s_q;
            pbit_d = rx_s_q;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Outputs: status pulses and the commit. All of them are registered below.
  always_comb begin
    data_d    = data_q;
    wr_d      = 1'b0;
    par_err_d = 1'b0;
    frm_err_d = 1'b0;
    ovf_d     = 1'b0;
    brk_d     = 1'b0;
    if (bus_io.rx_en && expire) begin
      if (state_q == StStop1 && !rx_s_q) begin
        if (shift_q == 8'h00 && !pbit_q) brk_d = 1'b1;
        else                             frm_err_d = 1'b1;
      end
      if (state_q == StStop2) begin
        if (!rx_s_q)                   frm_err_d = 1'b1;
        else if (perr_q)               par_err_d = 1'b1;
        else if (bus_io.out_fifo_full) ovf_d = 1'b1;
        else begin
          data_d = shift_q;
          wr_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      acc_q     <= 1'b0;
      perr_q    <= 1'b0;
      pbit_q    <= 1'b0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      perr_q    <= perr_d;
      pbit_q    <= pbit_d;
      data_q    <= data_d;
      wr_q      <= wr_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
      brk_q     <= brk_d;
    end
  end

  assign bus_io.busy           = (state_q != StIdle);
  assign bus_io.out_fifo_data  = data_q;
  assign bus_io.out_fifo_wr_en = wr_q;
  assign bus_io.parity_error   = par_err_q;
  assign bus_io.frame_error    = frm_err_q;
  assign bus_io.overflow       = ovf_q;
  assign bus_io.break_detected = brk_q;

endmodule
